// File: rtl/osd_dii_char_pkg.sv
// Shared constants for the DII character sink: header fields and parser states.
package osd_dii_char_pkg;

   localparam logic [1:0] TYPE_EVENT = 2'b10;

   localparam int HDR_TYPE_MSB = 15;
   localparam int HDR_TYPE_LSB = 14;
   localparam int HDR_SUB_MSB  = 13;
   localparam int HDR_SUB_LSB  = 10;

   typedef enum logic [2:0] {
      DEST    = 3'd0,
      SRC     = 3'd1,
      HDR     = 3'd2,
      PAYLOAD = 3'd3,
      DROP    = 3'd4
   } state_e;

endpackage

// File: rtl/osd_char_fifo.sv
// Synchronous FIFO with a registered head-of-queue output.
module osd_char_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;
   logic [WIDTH-1:0] r_rdata;
   logic [AW:0]      w_rd_nxt;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty   = (r_wr == r_rd);
   assign o_full    = (r_wr[AW] != r_rd[AW]) &&
                      (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;
   assign w_rd_nxt  = r_rd + {{AW{1'b0}}, w_pop_ok};
   assign o_rdata   = r_rdata;

   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr[AW-1:0]] <= i_wdata;
   end

   // Head register: bypass the write when it lands on the next read slot,
   // and read as zero whenever the queue drains.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_rdata <= '0;
      end else begin
         if (w_push_ok)
            r_wr <= r_wr + 1'b1;
         r_rd <= w_rd_nxt;
         if (w_push_ok && (r_wr[AW-1:0] == w_rd_nxt[AW-1:0]))
            r_rdata <= i_wdata;
         else if (w_pop_ok && (w_rd_nxt == r_wr))
            r_rdata <= '0;
         else if (w_pop_ok)
            r_rdata <= r_mem[w_rd_nxt[AW-1:0]];
      end
   end

endmodule

// File: rtl/osd_dii_char_sink.sv
// Debug-ring endpoint: parses DII packets and streams event payload chars.
module osd_dii_char_sink
   import osd_dii_char_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  i_id,
   input  logic [15:0] i_debug_in_data,
   input  logic        i_debug_in_last,
   input  logic        i_debug_in_valid,
   output logic        o_debug_in_ready,
   output logic [7:0]  o_out_char,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [15:0] o_pkt_count,
   output logic [15:0] o_drop_count
);

   state_e      r_state;
   logic        r_match;
   logic [15:0] r_pkt_count;
   logic [15:0] r_drop_count;

   state_e      w_state_nxt;
   logic        w_match_nxt;
   logic        w_pkt_inc;
   logic        w_drop_inc;
   logic        w_push;
   logic        w_xfer;
   logic        w_full;
   logic        w_empty;
   logic        w_is_event;

   assign o_debug_in_ready = (r_state == PAYLOAD) ? ~w_full : 1'b1;
   assign w_xfer     = i_debug_in_valid & o_debug_in_ready;
   assign w_is_event = r_match &&
      (i_debug_in_data[HDR_TYPE_MSB:HDR_TYPE_LSB] == TYPE_EVENT);

   always_comb begin
      w_state_nxt = r_state;
      w_match_nxt = r_match;
      w_pkt_inc   = 1'b0;
      w_drop_inc  = 1'b0;
      w_push      = 1'b0;
      if (w_xfer) begin
         unique case (r_state)
            DEST: begin
               if (i_debug_in_last) begin
                  w_drop_inc = 1'b1;
               end else begin
                  w_match_nxt = (i_debug_in_data == {6'b0, i_id});
                  w_state_nxt = SRC;
               end
            end
            SRC: begin
               w_state_nxt = i_debug_in_last ? DEST : HDR;
               w_drop_inc  = i_debug_in_last;
            end
            HDR: begin
               if (i_debug_in_last) begin
                  w_state_nxt = DEST;
                  w_pkt_inc   = w_is_event;
                  w_drop_inc  = ~w_is_event;
               end else begin
                  w_state_nxt = w_is_event ? PAYLOAD : DROP;
               end
            end
            PAYLOAD: begin
               w_push    = 1'b1;
               w_pkt_inc = i_debug_in_last;
               if (i_debug_in_last)
                  w_state_nxt = DEST;
            end
            DROP: begin
               w_drop_inc = i_debug_in_last;
               if (i_debug_in_last)
                  w_state_nxt = DEST;
            end
            default: w_state_nxt = DEST;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= DEST;
         r_match      <= 1'b0;
         r_pkt_count  <= '0;
         r_drop_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_match <= w_match_nxt;
         if (w_pkt_inc && (r_pkt_count != 16'hffff))
            r_pkt_count <= r_pkt_count + 16'd1;
         if (w_drop_inc && (r_drop_count != 16'hffff))
            r_drop_count <= r_drop_count + 16'd1;
      end
   end

   osd_char_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (i_debug_in_data[7:0]),
      .i_pop   (i_out_ready),
      .o_rdata (o_out_char),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign o_out_valid  = ~w_empty;
   assign o_pkt_count  = r_pkt_count;
   assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_osd_dii_char_sink.sv
// Directed bench for osd_dii_char_sink with hand-computed expectations.
module tb_osd_dii_char_sink;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  id;
   logic [15:0] din_data;
   logic        din_last;
   logic        din_valid;
   logic        din_ready;
   logic [7:0]  out_char;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] pkt_count;
   logic [15:0] drop_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   osd_dii_char_sink #(.DEPTH(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_id             (id),
      .i_debug_in_data  (din_data),
      .i_debug_in_last  (din_last),
      .i_debug_in_valid (din_valid),
      .o_debug_in_ready (din_ready),
      .o_out_char       (out_char),
      .o_out_valid      (out_valid),
      .i_out_ready      (out_ready),
      .o_pkt_count      (pkt_count),
      .o_drop_count     (drop_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic l);
      int t;
      din_valid = 1'b1;
      din_data  = d;
      din_last  = l;
      t = 0;
      while (!din_ready && t < 200) begin
         step();
         t++;
      end
      if (t >= 200) begin
         checks++;
         failures++;
         $error("FAIL send_timeout observed=ready0 expected=ready1");
      end
      step();
      din_valid = 1'b0;
      din_last  = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      id        = 10'd2;
      din_data  = '0;
      din_last  = 1'b0;
      din_valid = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      check("rst_ready", {15'b0, din_ready}, 16'd1);
      check("rst_valid", {15'b0, out_valid}, 16'd0);
      check("rst_char", {8'b0, out_char}, 16'h0000);
      check("rst_pkt", pkt_count, 16'd0);
      check("rst_drop", drop_count, 16'd0);
      rst = 1'b0;
      step();

      // matched event, two chars
      send(16'h0002, 1'b0);
      send(16'h0000, 1'b0);
      send(16'h8000, 1'b0);
      send(16'h0048, 1'b0);
      check("t1_valid0", {15'b0, out_valid}, 16'd1);
      check("t1_char0", {8'b0, out_char}, 16'h0048);
      send(16'h0069, 1'b1);
      check("t1_valid1", {15'b0, out_valid}, 16'd1);
      check("t1_char1", {8'b0, out_char}, 16'h0069);
      check("t1_pkt", pkt_count, 16'd1);
      check("t1_drop", drop_count, 16'd0);
      step();
      check("t1_empty", {15'b0, out_valid}, 16'd0);

      // foreign destination
      send(16'h0003, 1'b0);
      send(16'h0000, 1'b0);
      send(16'h8000, 1'b0);
      send(16'h0048, 1'b0);
      check("t2_ready", {15'b0, din_ready}, 16'd1);
      send(16'h0069, 1'b1);
      check("t2_valid", {15'b0, out_valid}, 16'd0);
      check("t2_drop", drop_count, 16'd1);
      check("t2_pkt", pkt_count, 16'd1);

      // backpressure: 12 chars into a depth-8 FIFO
      out_ready = 1'b0;
      send(16'h0002, 1'b0);
      send(16'h0000, 1'b0);
      send(16'h8000, 1'b0);
      for (int i = 0; i < 8; i++)
         send(16'h0041 + 16'(i), 1'b0);
      check("t3_full_ready", {15'b0, din_ready}, 16'd0);
      din_valid = 1'b1;
      din_data  = 16'h0049;
      step();
      step();
      step();
      check("t3_hold_ready", {15'b0, din_ready}, 16'd0);
      check("t3_hold_valid", {15'b0, out_valid}, 16'd1);
      check("t3_hold_char", {8'b0, out_char}, 16'h0041);
      out_ready = 1'b1;
      fork
         begin
            for (int i = 8; i < 12; i++)
               send(16'h0041 + 16'(i), i == 11);
         end
         begin
            for (int k = 0; k < 12; k++) begin
               int t;
               t = 0;
               while (!out_valid && t < 100) begin
                  step();
                  t++;
               end
               check("t3_wait", {15'b0, out_valid}, 16'd1);
               check("t3_char", {8'b0, out_char}, 16'h0041 + 16'(k));
               step();
            end
         end
      join
      check("t3_empty", {15'b0, out_valid}, 16'd0);
      check("t3_pkt", pkt_count, 16'd2);
      check("t3_drop", drop_count, 16'd1);

      // single-flit packet, then a valid event
      send(16'h0002, 1'b1);
      check("t4_drop", drop_count, 16'd2);
      send(16'h0002, 1'b0);
      send(16'h0000, 1'b0);
      send(16'h8000, 1'b0);
      send(16'h0055, 1'b1);
      check("t4_valid", {15'b0, out_valid}, 16'd1);
      check("t4_char", {8'b0, out_char}, 16'h0055);
      check("t4_pkt", pkt_count, 16'd3);
      check("t4_drop2", drop_count, 16'd2);
      step();

      // reset in the middle of a 6-flit event
      out_ready = 1'b0;
      send(16'h0002, 1'b0);
      send(16'h0000, 1'b0);
      send(16'h8000, 1'b0);
      send(16'h0031, 1'b0);
      check("t5_pre_valid", {15'b0, out_valid}, 16'd1);
      check("t5_pre_char", {8'b0, out_char}, 16'h0031);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t5_valid", {15'b0, out_valid}, 16'd0);
      check("t5_char", {8'b0, out_char}, 16'h0000);
      check("t5_pkt", pkt_count, 16'd0);
      check("t5_drop", drop_count, 16'd0);
      check("t5_ready", {15'b0, din_ready}, 16'd1);
      send(16'h0032, 1'b0);
      send(16'h0033, 1'b1);
      check("t5_mal_drop", drop_count, 16'd1);
      check("t5_mal_valid", {15'b0, out_valid}, 16'd0);
      check("t5_mal_pkt", pkt_count, 16'd0);

      // drop counter saturation
      out_ready = 1'b1;
      din_data  = 16'h0000;
      din_last  = 1'b1;
      din_valid = 1'b1;
      repeat (65533) step();
      check("t6_fffe", drop_count, 16'hfffe);
      repeat (7) step();
      din_valid = 1'b0;
      din_last  = 1'b0;
      check("t6_sat", drop_count, 16'hffff);
      step();
      check("t6_hold", drop_count, 16'hffff);
      check("t6_pkt", pkt_count, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/osd_dii_char_sink.md
# osd_dii_char_sink

Debug-ring endpoint that turns character event packets addressed to it into a byte stream for a system-side consumer. It drains one DII port of `debug_ring` and keeps only event packets whose destination matches `id`. The payload character of every accepted flit goes into a small FIFO, which presents a valid/ready char stream. Everything else is consumed and dropped, so the ring never stalls on foreign traffic.

## Interface
- `DEPTH`, default 8: character FIFO depth; power of two, ≥ 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `id`  in  10  module ring address; static after reset.
- `debug_in`  dii_channel slave  data 16, last 1, valid 1, ready 1  flits from the ring.
- `out_char`  out  8  head-of-FIFO character.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_char`.
- `pkt_count`  out  16  accepted event packets, saturating at 16'hffff.
- `drop_count`  out  16  dropped or malformed packets, saturating at 16'hffff.

## Operation
- Flit transfer occurs when `debug_in.valid & debug_in.ready`.
- Packet layout:
  - flit0: destination.
  - flit1: source.
  - flit2: header; `[15:14]` type, `[13:10]` subtype.
  - flit3 onward: payload, with the character in `[7:0]` and `[15:8]` ignored.
- FSM states:
  - DEST: `ready=1`.
    - `data == {6'b0,id}`: go to SRC, with `match` set.
    - Otherwise: go to SRC with `match` clear.
    - `last` set on this flit: malformed; `drop_count++`, stay in DEST.
  - SRC: `ready=1`.
    - `last` set: malformed; `drop_count++`, go to DEST.
    - Otherwise: go to HDR.
  - HDR: `ready=1`.
    - `match` set and type == EVENT (2'b10): go to PAYLOAD.
    - Otherwise: go to DROP.
    - `last` set here: `drop_count++` if not matched+EVENT, else `pkt_count++` (empty event); go to DEST.
  - PAYLOAD: `ready = !fifo_full`.
    - Each transfer pushes `data[7:0]`.
    - On `last`: `pkt_count++`, go to DEST.
  - DROP: `ready=1`.
    - On `last`: `drop_count++`, go to DEST.
- FIFO:
  - Push in PAYLOAD on transfer; pop on `out_valid & out_ready`.
  - Simultaneous push and pop when non-empty and non-full: occupancy unchanged.
  - When full, `ready=0` even if a pop happens in the same cycle; there is no pass-through.
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - Full when the MSBs differ and the rest are equal; empty when the pointers are equal.
- Counters:
  - 16-bit, increment by at most 1 per cycle, hold at 16'hffff.
- Reset, including mid-packet:
  - FSM returns to DEST and `match` clears.
  - FIFO is emptied: `out_valid=0`, `out_char=8'h00`.
  - Both counters go to 0.
  - The remaining flits of the interrupted packet are then parsed as a new packet and, if malformed, counted as dropped.

## Timing
- `debug_in.ready` is combinational from state and `fifo_full` only; it never depends on `debug_in.valid`.
- Char latency: a flit accepted in cycle N drives `out_valid=1` with that char in cycle N+1, when the FIFO was empty.
- Throughput: one flit per cycle in every state while the FIFO is not full.
- `out_char` and `out_valid` are stable while `out_valid & !out_ready`.
- Counters update in the cycle after the transfer carrying `last`.
- Reset values: `debug_in.ready=1` (DEST), `out_valid=0`, `out_char=0`, `pkt_count=0`, `drop_count=0`.

## Structure
- Package `osd_dii_char_pkg` holds:
  - `TYPE_EVENT = 2'b10`;
  - the header field bit positions;
  - the state enum `{DEST, SRC, HDR, PAYLOAD, DROP}`.
- Sub-module `osd_char_fifo` (`WIDTH`, `DEPTH`): synchronous FIFO with push, pop, full, empty and a registered read path. The top level holds the FSM, the `match` flag and the counters.

## Test plan
- Packet `{0002, 0000, 8000, 0048, 0069}` with `last` on the final flit, `id=2`, `out_ready=1` → `out_char` 0x48 then 0x69 on consecutive cycles starting 1 cycle after the transfer; `pkt_count=1`, `drop_count=0`.
- Same packet with destination 0x0003 → all 5 flits consumed at `ready=1`, no `out_valid`; `drop_count=1`.
- `id=2`, `DEPTH=8`, event with 12 chars and `out_ready=0` → 8 chars accepted, then `ready=0`. Raise `out_ready` → all 12 chars emerge in order; FIFO empties; pointer wrap is exercised.
- Single-flit packet (`last` on flit0), then a valid event → `drop_count=1`, and the event is decoded correctly afterwards.
- Assert `rst` after flit3 of a 6-flit event → `out_valid=0` and counters at 0 next cycle. Remaining flits are parsed as a malformed packet and dropped.
- 65540 single-char dropped packets → `drop_count` saturates at 16'hffff.
